// File: rtl/alu_cc_pipe_if.sv
// Handshake bundle between operand select, the execute ALU and the memory-stage register.
// master = upstream/downstream environment, slave = alu_cc_pipe.
interface alu_cc_pipe_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_fun;
    logic             set_cc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] val_e;
    logic             fun_err;
    logic [2:0]       cc;

    modport master (
        output in_valid, alu_a, alu_b, alu_fun, set_cc, flush, out_ready,
        input  in_ready, out_valid, val_e, fun_err, cc
    );

    modport slave (
        input  in_valid, alu_a, alu_b, alu_fun, set_cc, flush, out_ready,
        output in_ready, out_valid, val_e, fun_err, cc
    );
endinterface

// File: rtl/alu_cc_pipe.sv
// Two-stage Y86-64 execute ALU with valid/ready handshakes, flush and a retire-time CC register.
// Define ALU_EXT_OPS_EN to add OR (4), SHL (5) and SAR (6); otherwise codes 4-15 are illegal.
module alu_cc_pipe #(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           reset,
    alu_cc_pipe_if.slave   bus
);
    // Handshake: a beat moves when valid && ready at the rising edge. in_ready is
    // combinational from out_ready; flush discards the presented beat and both stages.
    if (WIDTH < 8 || (1 << SHW) != WIDTH) begin : g_bad_width
        $error("alu_cc_pipe: WIDTH must be a power of two >= 8");
    end

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [3:0]       s1_fun_q;
    logic             s1_set_cc_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] val_e_q;
    logic             fun_err_q;
    logic [2:0]       flags_q;
    logic             s2_set_cc_q;
    logic [2:0]       cc_q;

    logic [WIDTH-1:0] res_d;
    logic             fun_err_d;
    logic             of_d;
    logic [2:0]       flags_d;

    logic s2_adv;
    logic in_ready;
    logic retire;

    assign s2_adv   = !out_valid_q || bus.out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign retire   = out_valid_q && bus.out_ready;

    always_comb begin
        res_d     = '0;
        fun_err_d = 1'b0;
        of_d      = 1'b0;
        case (s1_fun_q)
            4'd0: begin
                res_d = s1_b_q + s1_a_q;
                of_d  = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (res_d[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            4'd1: begin
                res_d = s1_b_q - s1_a_q;
                of_d  = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (res_d[WIDTH-1] != s1_b_q[WIDTH-1]);
            end
            4'd2: res_d = s1_b_q & s1_a_q;
            4'd3: res_d = s1_b_q ^ s1_a_q;
`ifdef ALU_EXT_OPS_EN
            4'd4: res_d = s1_b_q | s1_a_q;
            4'd5: res_d = s1_b_q << s1_a_q[SHW-1:0];
            4'd6: res_d = $signed(s1_b_q) >>> s1_a_q[SHW-1:0];
`endif
            default: fun_err_d = 1'b1;
        endcase
        flags_d = {res_d == '0, res_d[WIDTH-1], of_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_fun_q    <= '0;
            s1_set_cc_q <= 1'b0;
            out_valid_q <= 1'b0;
            val_e_q     <= '0;
            fun_err_q   <= 1'b0;
            flags_q     <= '0;
            s2_set_cc_q <= 1'b0;
            cc_q        <= 3'b100;
        end else begin
            // CC commits on the output handshake only, even in a flush cycle.
            if (retire && s2_set_cc_q && !fun_err_q) begin
                cc_q <= flags_q;
            end
            if (bus.flush) begin
                s1_valid_q  <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                if (s2_adv) begin
                    out_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        val_e_q     <= res_d;
                        fun_err_q   <= fun_err_d;
                        flags_q     <= flags_d;
                        s2_set_cc_q <= s1_set_cc_q;
                    end
                end
                if (in_ready) begin
                    s1_valid_q <= bus.in_valid;
                    if (bus.in_valid) begin
                        s1_a_q      <= bus.alu_a;
                        s1_b_q      <= bus.alu_b;
                        s1_fun_q    <= bus.alu_fun;
                        s1_set_cc_q <= bus.set_cc;
                    end
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.val_e     = val_e_q;
    assign bus.fun_err   = fun_err_q;
    assign bus.cc        = cc_q;
endmodule
